// File: rtl/ext_mem_responder.sv
// Burst memory responder for the chip's trimmed AXI master port (AW/W/AR/R, no B, no RRESP).
// Independent write and read FSMs share one word-addressed, byte-strobed memory.
module ext_mem_responder #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 32,
   parameter int MEM_AW = 12
) (
   input  logic                clk,
   input  logic                rst_n,
   // write address
   input  logic                s_awvalid,
   output logic                s_awready,
   input  logic [ADDR_W-1:0]   s_awaddr,
   input  logic [7:0]          s_awlen,
   input  logic [2:0]          s_awsize,
   input  logic [1:0]          s_awburst,
   // write data
   input  logic                s_wvalid,
   output logic                s_wready,
   input  logic [DATA_W-1:0]   s_wdata,
   input  logic [DATA_W/8-1:0] s_wstrb,
   input  logic                s_wlast,
   // read address
   input  logic                s_arvalid,
   output logic                s_arready,
   input  logic [ADDR_W-1:0]   s_araddr,
   input  logic [7:0]          s_arlen,
   input  logic [2:0]          s_arsize,
   input  logic [1:0]          s_arburst,
   // read data
   output logic                s_rvalid,
   input  logic                s_rready,
   output logic [DATA_W-1:0]   s_rdata,
   output logic                s_rlast,
   // status and FSM visibility (1 = DATA state)
   output logic                err_wlast,
   output logic                w_state_dbg,
   output logic                r_state_dbg
);

   // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1.
   // Ready/valid outputs are registered; s_rvalid, once high, stays high until its handshake.

   localparam int DEPTH = 1 << MEM_AW;
   localparam int NBYTE = DATA_W / 8;

   typedef enum logic {W_IDLE, W_DATA} w_state_e;
   typedef enum logic {R_IDLE, R_DATA} r_state_e;

   function automatic logic [1:0] clamp_size(input logic [2:0] size);
      return (size > 3'd3) ? 2'd3 : size[1:0];
   endfunction

   logic [DATA_W-1:0] mem_q [0:DEPTH-1];

   // ---------------- write path ----------------
   w_state_e          w_state_q, w_state_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [7:0]        wlen_q, wlen_d;
   logic [7:0]        wbeat_q, wbeat_d;
   logic [1:0]        wsize_q, wsize_d;
   logic              wfixed_q, wfixed_d;
   logic              awready_q, awready_d;
   logic              wready_q, wready_d;
   logic              err_q, err_d;
   logic              mem_we;
   logic [ADDR_W-1:0] winc;
   logic [MEM_AW-1:0] w_idx;

   assign winc  = wfixed_q ? '0 : (ADDR_W'(1) << wsize_q);
   assign w_idx = waddr_q[MEM_AW+2:3];

   always_comb begin
      w_state_d = w_state_q;
      waddr_d   = waddr_q;
      wlen_d    = wlen_q;
      wbeat_d   = wbeat_q;
      wsize_d   = wsize_q;
      wfixed_d  = wfixed_q;
      err_d     = err_q;
      mem_we    = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (s_awvalid && awready_q) begin
               waddr_d   = s_awaddr;
               wlen_d    = s_awlen;
               wsize_d   = clamp_size(s_awsize);
               wfixed_d  = (s_awburst == 2'b00);
               wbeat_d   = 8'd0;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (s_wvalid && wready_q) begin
               mem_we  = 1'b1;
               waddr_d = waddr_q + winc;
               wbeat_d = wbeat_q + 8'd1;
               // Either a missing WLAST on the final beat or an early WLAST ends the burst.
               if (wbeat_q == wlen_q) begin
                  if (!s_wlast) err_d = 1'b1;
                  w_state_d = W_IDLE;
               end else if (s_wlast) begin
                  err_d     = 1'b1;
                  w_state_d = W_IDLE;
               end
            end
         end
         default: w_state_d = W_IDLE;
      endcase
      awready_d = (w_state_d == W_IDLE);
      wready_d  = (w_state_d == W_DATA);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state_q <= W_IDLE;
         waddr_q   <= '0;
         wlen_q    <= '0;
         wbeat_q   <= '0;
         wsize_q   <= '0;
         wfixed_q  <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         waddr_q   <= waddr_d;
         wlen_q    <= wlen_d;
         wbeat_q   <= wbeat_d;
         wsize_q   <= wsize_d;
         wfixed_q  <= wfixed_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         err_q     <= err_d;
      end
   end

   // Memory is deliberately not reset; completed beats survive rst_n.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < NBYTE; b++) begin
            if (s_wstrb[b]) mem_q[w_idx][8*b +: 8] <= s_wdata[8*b +: 8];
         end
      end
   end

   // ---------------- read path ----------------
   r_state_e          r_state_q, r_state_d;
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic [7:0]        rlen_q, rlen_d;
   logic [7:0]        rbeat_q, rbeat_d;
   logic [1:0]        rsize_q, rsize_d;
   logic              rfixed_q, rfixed_d;
   logic              arready_q, arready_d;
   logic              rvalid_q, rvalid_d;
   logic              rlast_q, rlast_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [ADDR_W-1:0] rinc;
   logic [ADDR_W-1:0] r_next_addr;
   logic [MEM_AW-1:0] r_start_idx;
   logic [MEM_AW-1:0] r_next_idx;

   assign rinc        = rfixed_q ? '0 : (ADDR_W'(1) << rsize_q);
   assign r_next_addr = raddr_q + rinc;
   assign r_start_idx = s_araddr[MEM_AW+2:3];
   assign r_next_idx  = r_next_addr[MEM_AW+2:3];

   // Fetches register the array value at the edge, so a same-edge write is not seen.
   always_comb begin
      r_state_d = r_state_q;
      raddr_d   = raddr_q;
      rlen_d    = rlen_q;
      rbeat_d   = rbeat_q;
      rsize_d   = rsize_q;
      rfixed_d  = rfixed_q;
      rlast_d   = rlast_q;
      rdata_d   = rdata_q;
      case (r_state_q)
         R_IDLE: begin
            if (s_arvalid && arready_q) begin
               raddr_d   = s_araddr;
               rlen_d    = s_arlen;
               rsize_d   = clamp_size(s_arsize);
               rfixed_d  = (s_arburst == 2'b00);
               rbeat_d   = 8'd0;
               rdata_d   = mem_q[r_start_idx];
               rlast_d   = (s_arlen == 8'd0);
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (s_rready && rvalid_q) begin
               if (rbeat_q == rlen_q) begin
                  rlast_d   = 1'b0;
                  r_state_d = R_IDLE;
               end else begin
                  raddr_d = r_next_addr;
                  rdata_d = mem_q[r_next_idx];
                  rbeat_d = rbeat_q + 8'd1;
                  rlast_d = ((rbeat_q + 8'd1) == rlen_q);
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      arready_d = (r_state_d == R_IDLE);
      rvalid_d  = (r_state_d == R_DATA);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state_q <= R_IDLE;
         raddr_q   <= '0;
         rlen_q    <= '0;
         rbeat_q   <= '0;
         rsize_q   <= '0;
         rfixed_q  <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rdata_q   <= '0;
      end else begin
         r_state_q <= r_state_d;
         raddr_q   <= raddr_d;
         rlen_q    <= rlen_d;
         rbeat_q   <= rbeat_d;
         rsize_q   <= rsize_d;
         rfixed_q  <= rfixed_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         rdata_q   <= rdata_d;
      end
   end

   assign s_awready   = awready_q;
   assign s_wready    = wready_q;
   assign err_wlast   = err_q;
   assign s_arready   = arready_q;
   assign s_rvalid    = rvalid_q;
   assign s_rlast     = rlast_q;
   assign s_rdata     = rdata_q;
   assign w_state_dbg = (w_state_q == W_DATA);
   assign r_state_dbg = (r_state_q == R_DATA);

endmodule

// File: tb/tb_ext_mem_responder.sv
// Self-checking bench for ext_mem_responder: directed scenarios plus randomized bursts
// checked against an array model of the memory.
module tb_ext_mem_responder;

   localparam int DEPTH = 4096;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_awvalid = 1'b0, s_awready;
   logic [31:0] s_awaddr = '0;
   logic [7:0]  s_awlen = '0;
   logic [2:0]  s_awsize = '0;
   logic [1:0]  s_awburst = '0;
   logic        s_wvalid = 1'b0, s_wready;
   logic [63:0] s_wdata = '0;
   logic [7:0]  s_wstrb = '0;
   logic        s_wlast = 1'b0;
   logic        s_arvalid = 1'b0, s_arready;
   logic [31:0] s_araddr = '0;
   logic [7:0]  s_arlen = '0;
   logic [2:0]  s_arsize = '0;
   logic [1:0]  s_arburst = '0;
   logic        s_rvalid, s_rready = 1'b0;
   logic [63:0] s_rdata;
   logic        s_rlast;
   logic        err_wlast, w_state_dbg, r_state_dbg;

   always #5 clk = ~clk;

   ext_mem_responder dut (
      .clk(clk), .rst_n(rst_n),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
      .s_awsize(s_awsize), .s_awburst(s_awburst),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
      .s_arsize(s_arsize), .s_arburst(s_arburst),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rlast(s_rlast),
      .err_wlast(err_wlast), .w_state_dbg(w_state_dbg), .r_state_dbg(r_state_dbg)
   );

   int tests_run = 0;
   int tests_failed = 0;

   logic [63:0] exp_mem [0:DEPTH-1];
   logic [63:0] wd [0:255];
   logic [7:0]  ws [0:255];
   logic [63:0] got_q [$];
   logic [63:0] exp_q [$];

   // ---------------- reference model ----------------
   function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                             input logic [1:0] burst);
      return (burst == 2'd0) ? a : a + (32'd1 << size);
   endfunction

   function automatic void model_write(input logic [31:0] addr, input logic [2:0] size,
                                       input logic [1:0] burst, input int n);
      logic [31:0] a;
      a = addr;
      for (int i = 0; i < n; i++) begin
         for (int b = 0; b < 8; b++)
            if (ws[i][b]) exp_mem[a[14:3]][8*b +: 8] = wd[i][8*b +: 8];
         a = next_addr(a, size, burst);
      end
   endfunction

   function automatic void model_read(input logic [31:0] addr, input logic [7:0] len,
                                      input logic [2:0] size, input logic [1:0] burst);
      logic [31:0] a;
      a = addr;
      exp_q.delete();
      for (int i = 0; i <= int'(len); i++) begin
         exp_q.push_back(exp_mem[a[14:3]]);
         a = next_addr(a, size, burst);
      end
   endfunction

   // ---------------- drivers ----------------
   task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int nsend, input int last_at,
                           output int timeout);
      int c;
      timeout = 0;
      s_awaddr = addr; s_awlen = len; s_awsize = size; s_awburst = burst; s_awvalid = 1'b1;
      c = 0;
      do begin @(negedge clk); c++; end while (!s_awready && c < 200);
      if (!s_awready) timeout = 1;
      @(posedge clk); #1;
      s_awvalid = 1'b0;
      for (int i = 0; i < nsend; i++) begin
         s_wvalid = 1'b1; s_wdata = wd[i]; s_wstrb = ws[i]; s_wlast = (i == last_at);
         c = 0;
         do begin @(negedge clk); c++; end while (!s_wready && c < 200);
         if (!s_wready) timeout = 1;
         @(posedge clk); #1;
      end
      s_wvalid = 1'b0; s_wlast = 1'b0;
   endtask

   // mode: 0 = rready always 1, 1 = alternating 1,0,..., 2 = random
   task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input int mode,
                          output logic first_valid, output logic [63:0] first_data,
                          output int lasterr, output int stab_err, output int timeout,
                          output logic rvalid_after, output logic arready_after);
      int c, nb, cyc;
      logic held, held_l;
      logic [63:0] held_d;
      got_q.delete();
      lasterr = 0; stab_err = 0; timeout = 0; held = 0; held_d = '0; held_l = 0;
      s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst; s_arvalid = 1'b1;
      c = 0;
      do begin @(negedge clk); c++; end while (!s_arready && c < 200);
      if (!s_arready) timeout = 1;
      @(posedge clk); #1;
      s_arvalid = 1'b0;
      first_valid = s_rvalid; first_data = s_rdata;
      nb = 0; cyc = 0;
      while (nb <= int'(len) && cyc < 4000) begin
         s_rready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
         @(negedge clk);
         if (s_rvalid) begin
            if (held && (s_rdata !== held_d || s_rlast !== held_l)) stab_err++;
            if (s_rready) begin
               got_q.push_back(s_rdata);
               if (s_rlast !== (nb == int'(len))) lasterr++;
               nb++; held = 0;
            end else begin
               held = 1; held_d = s_rdata; held_l = s_rlast;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      s_rready = 1'b0;
      if (nb <= int'(len)) timeout = 1;
      rvalid_after = s_rvalid; arready_after = s_arready;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      tests_run++;
      if ({s_awready, s_wready, s_arready, s_rvalid, s_rlast, err_wlast} !== 6'b0 || s_rdata !== 64'd0) begin
         tests_failed++;
         $display("FAIL reset_values: rdy/vld/last/err=%b rdata=%h, required all zero",
                  {s_awready, s_wready, s_arready, s_rvalid, s_rlast, err_wlast}, s_rdata);
      end
      @(negedge clk); rst_n = 1'b1; #1;
      tests_run++;
      if (s_awready !== 1'b0 || s_arready !== 1'b0) begin
         tests_failed++;
         $display("FAIL ready_before_edge: aw=%b ar=%b, required 0 0", s_awready, s_arready);
      end
      @(posedge clk); #1;
      tests_run++;
      if (s_awready !== 1'b1 || s_arready !== 1'b1 || s_wready !== 1'b0 || s_rvalid !== 1'b0) begin
         tests_failed++;
         $display("FAIL ready_after_edge: aw=%b ar=%b w=%b rv=%b, required 1 1 0 0",
                  s_awready, s_arready, s_wready, s_rvalid);
      end
   endtask

   task automatic preload_zero();
      int to;
      for (int i = 0; i < 256; i++) begin wd[i] = '0; ws[i] = 8'hFF; end
      for (int k = 0; k < 16; k++) begin
         do_write(32'(k * 2048), 8'd255, 3'd3, 2'd1, 256, 255, to);
         model_write(32'(k * 2048), 3'd3, 2'd1, 256);
      end
   endtask

   task automatic test_single();
      int to, le, se, to2;
      logic fv, rva, ara;
      logic [63:0] fd;
      wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
      do_write(32'h100, 8'd0, 3'd3, 2'd1, 1, 0, to);
      model_write(32'h100, 3'd3, 2'd1, 1);
      tests_run++;
      if (s_awready !== 1'b1 || s_wready !== 1'b0 || to != 0) begin
         tests_failed++;
         $display("FAIL single_wr_done: aw=%b w=%b timeout=%0d, required 1 0 0", s_awready, s_wready, to);
      end
      do_read(32'h100, 8'd0, 3'd3, 2'd1, 0, fv, fd, le, se, to2, rva, ara);
      tests_run++;
      if (fv !== 1'b1 || fd !== 64'h1122334455667788 || le != 0 || to2 != 0) begin
         tests_failed++;
         $display("FAIL single_rd: rvalid=%b rdata=%h lasterr=%0d timeout=%0d, required 1 1122334455667788 0 0",
                  fv, fd, le, to2);
      end
      tests_run++;
      if (rva !== 1'b0 || ara !== 1'b1) begin
         tests_failed++;
         $display("FAIL single_rd_end: rvalid=%b arready=%b, required 0 1", rva, ara);
      end
   endtask

   task automatic test_incr_stall();
      int to, le, se, to2;
      logic fv, rva, ara;
      logic [63:0] fd;
      for (int i = 0; i < 8; i++) begin wd[i] = 64'(i); ws[i] = 8'hFF; end
      do_write(32'h2000, 8'd7, 3'd3, 2'd1, 8, 7, to);
      model_write(32'h2000, 3'd3, 2'd1, 8);
      do_read(32'h2000, 8'd7, 3'd3, 2'd1, 1, fv, fd, le, se, to2, rva, ara);
      tests_run++;
      if (got_q.size() != 8 || le != 0 || se != 0 || to != 0 || to2 != 0) begin
         tests_failed++;
         $display("FAIL incr_stall_proto: beats=%0d lasterr=%0d stable_err=%0d timeouts=%0d/%0d, required 8 0 0 0/0",
                  got_q.size(), le, se, to, to2);
      end
      for (int i = 0; i < 8 && i < got_q.size(); i++) begin
         tests_run++;
         if (got_q[i] !== 64'(i)) begin
            tests_failed++;
            $display("FAIL incr_stall_data[%0d]: got %h, required %h", i, got_q[i], 64'(i));
         end
      end
   endtask

   task automatic test_fixed_strobe();
      int to, le, se, to2;
      logic fv, rva, ara;
      logic [63:0] fd, tmp;
      for (int k = 0; k < 4; k++) begin
         tmp = 64'hEEEE_EEEE_EEEE_EEEE;
         tmp[8*k +: 8] = 8'hA0 + 8'(k);
         wd[k] = tmp; ws[k] = 8'h01 << k;
      end
      do_write(32'h40, 8'd3, 3'd3, 2'd0, 4, 3, to);
      model_write(32'h40, 3'd3, 2'd0, 4);
      do_read(32'h40, 8'd0, 3'd3, 2'd1, 0, fv, fd, le, se, to2, rva, ara);
      tests_run++;
      if (fd !== 64'h00000000A3A2A1A0 || fd !== exp_mem[8] || to != 0 || to2 != 0) begin
         tests_failed++;
         $display("FAIL fixed_strobe: got %h, required 00000000a3a2a1a0", fd);
      end
   endtask

   task automatic test_alias_wrap();
      int to, le, se, to2;
      logic fv, rva, ara;
      logic [63:0] fd, a0;
      a0 = {$urandom, $urandom};
      wd[0] = a0; ws[0] = 8'hFF;
      do_write(32'h8000, 8'd0, 3'd3, 2'd1, 1, 0, to);
      model_write(32'h8000, 3'd3, 2'd1, 1);
      do_read(32'h0, 8'd0, 3'd3, 2'd1, 0, fv, fd, le, se, to2, rva, ara);
      tests_run++;
      if (fd !== a0) begin
         tests_failed++;
         $display("FAIL alias_8000: read 0x0 got %h, required %h", fd, a0);
      end
      for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
      do_write(32'h7FF8, 8'd3, 3'd3, 2'd1, 4, 3, to);
      model_write(32'h7FF8, 3'd3, 2'd1, 4);
      do_read(32'h0, 8'd1, 3'd3, 2'd1, 2, fv, fd, le, se, to2, rva, ara);
      tests_run++;
      if (got_q.size() != 2 || got_q[0] !== wd[1] || got_q[1] !== wd[2]) begin
         tests_failed++;
         $display("FAIL wrap_word0: beats=%0d got %h %h, required %h %h", got_q.size(),
                  got_q.size() > 0 ? got_q[0] : 64'd0, got_q.size() > 1 ? got_q[1] : 64'd0, wd[1], wd[2]);
      end
      do_read(32'h7FF8, 8'd0, 3'd3, 2'd1, 0, fv, fd, le, se, to2, rva, ara);
      tests_run++;
      if (fd !== wd[0]) begin
         tests_failed++;
         $display("FAIL wrap_word4095: got %h, required %h", fd, wd[0]);
      end
   endtask

   task automatic test_wlast_err();
      int to, le, se, to2;
      logic fv, rva, ara;
      logic [63:0] fd;
      tests_run++;
      if (err_wlast !== 1'b0) begin
         tests_failed++;
         $display("FAIL err_clean: err_wlast=%b, required 0", err_wlast);
      end
      for (int i = 0; i < 4; i++) begin wd[i] = 64'hC0DE_0000_0000_0000 + 64'(i); ws[i] = 8'hFF; end
      do_write(32'h3000, 8'd3, 3'd3, 2'd1, 2, 1, to);
      model_write(32'h3000, 3'd3, 2'd1, 2);
      tests_run++;
      if (err_wlast !== 1'b1 || s_awready !== 1'b1 || s_wready !== 1'b0) begin
         tests_failed++;
         $display("FAIL early_wlast: err=%b aw=%b w=%b, required 1 1 0", err_wlast, s_awready, s_wready);
      end
      do_read(32'h3000, 8'd3, 3'd3, 2'd1, 0, fv, fd, le, se, to2, rva, ara);
      tests_run++;
      if (got_q.size() != 4 || got_q[0] !== wd[0] || got_q[1] !== wd[1] ||
          got_q[2] !== 64'd0 || got_q[3] !== 64'd0) begin
         tests_failed++;
         $display("FAIL early_wlast_words: beats=%0d, required 2 written words then zeros", got_q.size());
      end
   endtask

   task automatic test_reset_midburst();
      int c, le, se, to2;
      logic fv, rva, ara;
      logic [63:0] fd;
      s_araddr = 32'h2000; s_arlen = 8'd7; s_arsize = 3'd3; s_arburst = 2'd1; s_arvalid = 1'b1;
      c = 0;
      do begin @(negedge clk); c++; end while (!s_arready && c < 200);
      @(posedge clk); #1;
      s_arvalid = 1'b0; s_rready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (s_rvalid !== 1'b1 || s_rdata !== 64'd3) begin
         tests_failed++;
         $display("FAIL midburst_beat3: rvalid=%b rdata=%h, required 1 3", s_rvalid, s_rdata);
      end
      #1 rst_n = 1'b0;
      #1;
      tests_run++;
      if (s_rvalid !== 1'b0 || s_rdata !== 64'd0 || s_arready !== 1'b0 || s_rlast !== 1'b0 || err_wlast !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_reset: rvalid=%b rdata=%h arready=%b rlast=%b err=%b, required 0 0 0 0 0",
                  s_rvalid, s_rdata, s_arready, s_rlast, err_wlast);
      end
      s_rready = 1'b0;
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (s_arready !== 1'b1 || s_rvalid !== 1'b0) begin
         tests_failed++;
         $display("FAIL post_reset_ready: arready=%b rvalid=%b, required 1 0", s_arready, s_rvalid);
      end
      do_read(32'h2000, 8'd7, 3'd3, 2'd1, 2, fv, fd, le, se, to2, rva, ara);
      tests_run++;
      if (got_q.size() != 8 || le != 0 || se != 0 || to2 != 0) begin
         tests_failed++;
         $display("FAIL post_reset_read_proto: beats=%0d lasterr=%0d stable_err=%0d, required 8 0 0",
                  got_q.size(), le, se);
      end else begin
         for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (got_q[i] !== 64'(i)) begin
               tests_failed++;
               $display("FAIL post_reset_data[%0d]: got %h, required %h", i, got_q[i], 64'(i));
            end
         end
      end
   endtask

   task automatic test_missing_wlast();
      int to;
      for (int i = 0; i < 2; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
      do_write(32'h3800, 8'd1, 3'd3, 2'd1, 2, -1, to);
      model_write(32'h3800, 3'd3, 2'd1, 2);
      tests_run++;
      if (err_wlast !== 1'b1 || s_awready !== 1'b1 || to != 0) begin
         tests_failed++;
         $display("FAIL missing_wlast: err=%b aw=%b timeout=%0d, required 1 1 0", err_wlast, s_awready, to);
      end
   endtask

   task automatic test_concurrent();
      int to, le, se, to2;
      logic fv, rva, ara;
      logic [63:0] fd;
      for (int i = 0; i < 8; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
      model_read(32'h2000, 8'd7, 3'd3, 2'd1);
      fork
         do_write(32'h5000, 8'd7, 3'd3, 2'd1, 8, 7, to);
         do_read(32'h2000, 8'd7, 3'd3, 2'd1, 0, fv, fd, le, se, to2, rva, ara);
      join
      model_write(32'h5000, 3'd3, 2'd1, 8);
      tests_run++;
      if (got_q != exp_q || to != 0 || to2 != 0) begin
         tests_failed++;
         $display("FAIL concurrent_read: beats=%0d timeouts=%0d/%0d, required 8 beats matching model",
                  got_q.size(), to, to2);
      end
      model_read(32'h5000, 8'd7, 3'd3, 2'd1);
      do_read(32'h5000, 8'd7, 3'd3, 2'd1, 2, fv, fd, le, se, to2, rva, ara);
      tests_run++;
      if (got_q != exp_q) begin
         tests_failed++;
         $display("FAIL concurrent_write: readback beats=%0d differs from model", got_q.size());
      end
   endtask

   task automatic test_random();
      int to, le, se, to2;
      logic fv, rva, ara;
      logic [63:0] fd;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      for (int it = 0; it < 24; it++) begin
         addr = $urandom; len = 8'($urandom_range(0, 15));
         size = 3'($urandom_range(0, 3)); burst = 2'($urandom_range(0, 3));
         for (int i = 0; i <= int'(len); i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
         do_write(addr, len, size, burst, int'(len) + 1, int'(len), to);
         model_write(addr, size, burst, int'(len) + 1);
         model_read(addr, len, size, burst);
         do_read(addr, len, size, burst, 2, fv, fd, le, se, to2, rva, ara);
         tests_run++;
         if (got_q != exp_q || le != 0 || se != 0 || to != 0 || to2 != 0) begin
            tests_failed++;
            $display("FAIL random[%0d]: addr=%h len=%0d size=%0d burst=%0d beats=%0d lasterr=%0d stable_err=%0d first got %h required %h",
                     it, addr, len, size, burst, got_q.size(), le, se,
                     got_q.size() > 0 ? got_q[0] : 64'd0, exp_q[0]);
         end
      end
   endtask

   initial begin
      #2;
      test_reset();
      preload_zero();
      test_single();
      test_incr_stall();
      test_fixed_strobe();
      test_alias_wrap();
      test_wlast_err();
      test_reset_midburst();
      test_missing_wlast();
      test_concurrent();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/ext_mem_responder.md
# ext_mem_responder

AXI-style burst memory responder sitting on the chip's external master port (`ext_m_*`) in simulation and FPGA bring-up: it accepts the write and read bursts the 64-core chip issues and backs them with an on-block word-addressed memory. It is the slave end of the chip's trimmed AXI master interface, which has AW, W, AR and R channels and no B channel and no RRESP. Benches use it as the external DRAM model for matrix-block load and store traffic.

## Interface
- DATA_W, 64, data beat width; only 64 is supported (8 byte lanes).
- ADDR_W, 32, byte address width.
- MEM_AW, 12, log2 of memory depth in 64-bit words (default 4096 words = 32 KiB).
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_awvalid/s_awready  in/out  1/1  write-address handshake.
- s_awaddr  in  ADDR_W  burst start byte address.
- s_awlen  in  8  number of beats minus 1.
- s_awsize  in  3  log2 bytes per beat (0..3).
- s_awburst  in  2  0 = FIXED, 1 = INCR, 2/3 = treated as INCR.
- s_wvalid/s_wready  in/out  1/1  write-data handshake.
- s_wdata  in  DATA_W  write beat.
- s_wstrb  in  8  byte enables; bit n writes wdata[8n+7:8n].
- s_wlast  in  1  final write beat marker.
- s_arvalid/s_arready, s_araddr, s_arlen, s_arsize, s_arburst: read-address channel, same widths and meanings as AW.
- s_rvalid/s_rready  out/in  1/1  read-data handshake.
- s_rdata  out  DATA_W  read beat.
- s_rlast  out  1  final read beat marker.
- err_wlast  out  1  sticky flag: a WLAST/AWLEN mismatch was seen.

## Operation
- Word index = addr[MEM_AW+2:3]. Upper address bits are ignored, so addresses alias modulo 2^(MEM_AW+3) bytes. Bits [2:0] never select lanes; WSTRB alone does.
- Beat address update: INCR adds (1 << size) bytes; FIXED adds 0. Index arithmetic wraps mod 2^MEM_AW; no 4 KiB boundary check.
- Memory contents are not reset.
- Write FSM, states W_IDLE and W_DATA:
  - W_IDLE: s_awready = 1, s_wready = 0. On an AW handshake, latch address, len, size and burst, clear the beat counter, and go to W_DATA.
  - W_DATA: s_awready = 0, s_wready = 1. Each W handshake writes the strobed bytes at the current index, then advances the address and beat counter.
  - Normal end: the handshake on beat == len returns the FSM to W_IDLE. If s_wlast = 0 on that beat, set err_wlast.
  - Early end: s_wlast = 1 on beat < len sets err_wlast, writes that beat, and ends the burst (returns to W_IDLE).
- Read FSM, states R_IDLE and R_DATA:
  - R_IDLE: s_arready = 1. On an AR handshake, latch the parameters, load s_rdata from the start index, and go to R_DATA.
  - R_DATA: s_rvalid = 1, with s_rlast = (beat == len).
  - rready = 0: s_rdata, s_rlast and beat are held.
  - Handshake on a non-last beat: load the next index's data and increment beat.
  - Handshake on the last beat: return to R_IDLE.
- The read and write paths are fully independent and may run concurrently.
- Same-cycle read fetch and write to one word: the fetched data is the pre-write value.

## Timing
- Reset values: s_awready = 0, s_wready = 0, s_arready = 0, s_rvalid = 0, s_rlast = 0, s_rdata = 0, err_wlast = 0. Both FSMs reset to IDLE.
- The ready signals are registered. s_awready and s_arready rise on the first clk edge after rst_n deasserts.
- AW accepted at edge N: s_awready = 0 and s_wready = 1 from N+1. W beats can then be accepted one per cycle.
- Last W handshake at edge M: s_wready = 0 and s_awready = 1 from M+1, so back-to-back bursts have a 1-cycle bubble.
- AR accepted at edge N: s_arready = 0, s_rvalid = 1 and beat-0 data are valid from N+1 (1-cycle latency).
- With s_rready held high, the read path delivers one beat per cycle.
- Last R handshake at edge M: s_rvalid = 0 and s_arready = 1 from M+1.
- s_rvalid never drops without a handshake. s_rdata and s_rlast are stable while s_rvalid = 1 and s_rready = 0.
- rst_n asserted mid-burst: the outputs above clear immediately (asynchronously). Beats already written remain in memory. The partial burst is abandoned, with no resume after reset.
- err_wlast clears only on reset.

## Test plan
- Single-beat write then read: AW 0x100, len 0, wdata 0x1122334455667788, strb 0xFF, wlast 1; then AR 0x100 len 0 -> rdata 0x1122334455667788 with rlast = 1, one cycle after AR accept.
- INCR burst with stalls: write 8 beats at 0x2000 with data 0..7; read 8 beats with rready toggling 1,0,1,0 -> data 0..7 in order; rlast only on beat 7; rdata stable during stalls.
- FIXED burst plus partial strobes: write 4 beats to 0x40 with strb 0x01, 0x02, 0x04, 0x08, data byte k = 0xA0+k in lane k -> readback of 0x40 = 0x00000000A3A2A1A0 (upper lanes preloaded 0).
- Address aliasing: with MEM_AW = 12, write at 0x8000, read at 0x0000 -> same word; an INCR burst starting at word 4095 wraps to word 0.
- WLAST error: awlen 3 with wlast on beat 1 -> err_wlast = 1; s_awready = 1 the next cycle; only 2 words written.
- Reset mid-burst: assert rst_n low during beat 3 of an 8-beat read -> s_rvalid = 0 immediately. After release, s_arready = 1 at the first edge, and a new read returns correct data.
